// File: rtl/voice_ctrl_if.sv
// Bundle of the UART-side message inputs and the per-voice status outputs
// of the polyphonic keyboard voice controller.
interface voice_ctrl_if #(
    parameter int C_UART_DATA_WIDTH = 8,
    parameter int C_VOICES          = 4,
    parameter int C_ERR_WIDTH       = 8
) ();
    logic                                          UART_valid;
    logic                                          UART_err;
    logic [C_UART_DATA_WIDTH-1:0]                  UART_msg;
    logic [C_VOICES-1:0]                           voiceActive;
    logic [C_VOICES*(C_UART_DATA_WIDTH-1)-1:0]     voiceNote;
    logic [C_VOICES-1:0]                           voiceStart;
    logic                                          steal;
    logic [C_ERR_WIDTH-1:0]                        errCnt;

    // The message source (UART side) drives bytes and observes voice state
    modport master (
        output UART_valid, UART_err, UART_msg,
        input  voiceActive, voiceNote, voiceStart, steal, errCnt
    );

    // The voice controller consumes bytes and publishes voice state
    modport slave (
        input  UART_valid, UART_err, UART_msg,
        output voiceActive, voiceNote, voiceStart, steal, errCnt
    );
endinterface

// File: rtl/voice_ctrl.sv
// Polyphonic keyboard voice controller: decodes UART note-on/note-off bytes,
// allocates them to independent timed voices and steals the voice nearest
// to expiry when every voice is busy.
module voice_ctrl #(
    parameter int C_CLK_FRQ         = 100_000_000,
    parameter int C_MUSIC           = 500,
    parameter int C_UART_DATA_WIDTH = 8,
    parameter int C_VOICES          = 4,
    parameter int C_ERR_WIDTH       = 8
) (
    input  logic        clk,
    input  logic        rstb,
    voice_ctrl_if.slave bus
);
    localparam int C_DUR = C_CLK_FRQ / 1000 * C_MUSIC;
    localparam int N     = C_UART_DATA_WIDTH - 1;
    localparam int TW    = (C_DUR > 2) ? $clog2(C_DUR) : 1;
    localparam int IW    = (C_VOICES > 1) ? $clog2(C_VOICES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(C_DUR - 1);

    logic [C_VOICES-1:0]           activeQ, activeD;
    logic [C_VOICES-1:0][N-1:0]    noteQ, noteD;
    logic [C_VOICES-1:0][TW-1:0]   timerQ, timerD;
    logic [C_VOICES-1:0]           startQ, startD;
    logic                          stealQ, stealD;
    logic [C_ERR_WIDTH-1:0]        errCntQ, errCntD;

    logic [C_VOICES-1:0]           liveVec;
    logic [C_VOICES-1:0]           hitVec;
    logic [C_VOICES-1:0][TW-1:0]   agedTimer;
    logic [N-1:0]                  msgCode;
    logic                          msgOn;
    logic                          freeFound;
    logic [IW-1:0]                 selIdx;

    assign msgCode = bus.UART_msg[N-1:0];
    assign msgOn   = bus.UART_msg[C_UART_DATA_WIDTH-1];

    // Apply expiry first: a voice whose timer is already 0 counts as free this cycle
    always_comb begin
        liveVec   = '0;
        hitVec    = '0;
        agedTimer = '0;
        for (int k = 0; k < C_VOICES; k++) begin
            liveVec[k]   = activeQ[k] && (timerQ[k] != '0);
            agedTimer[k] = liveVec[k] ? (timerQ[k] - TW'(1)) : '0;
            hitVec[k]    = liveVec[k] && (noteQ[k] == msgCode);
        end
    end

    // Decode the message and pick a voice: retrigger, else first free, else steal oldest
    always_comb begin
        activeD   = liveVec;
        timerD    = agedTimer;
        noteD     = noteQ;
        startD    = '0;
        stealD    = 1'b0;
        errCntD   = errCntQ;
        freeFound = 1'b0;
        selIdx    = '0;
        if (bus.UART_err) begin
            if (errCntQ != '1) begin
                errCntD = errCntQ + C_ERR_WIDTH'(1);
            end
        end else if (bus.UART_valid) begin
            if (msgOn) begin
                if (msgCode != '0) begin
                    if (|hitVec) begin
                        for (int k = 0; k < C_VOICES; k++) begin
                            if (hitVec[k]) begin
                                timerD[k] = TIMER_LOAD;
                                startD[k] = 1'b1;
                            end
                        end
                    end else begin
                        for (int k = 0; k < C_VOICES; k++) begin
                            if (!freeFound && !liveVec[k]) begin
                                freeFound = 1'b1;
                                selIdx    = IW'(k);
                            end
                        end
                        if (!freeFound) begin
                            for (int k = 1; k < C_VOICES; k++) begin
                                if (timerQ[k] < timerQ[selIdx]) begin
                                    selIdx = IW'(k);
                                end
                            end
                            stealD = 1'b1;
                        end
                        activeD[selIdx] = 1'b1;
                        noteD[selIdx]   = msgCode;
                        timerD[selIdx]  = TIMER_LOAD;
                        startD[selIdx]  = 1'b1;
                    end
                end
            end else if (msgCode == '0) begin
                activeD = '0;
                timerD  = '0;
            end else begin
                for (int k = 0; k < C_VOICES; k++) begin
                    if (hitVec[k]) begin
                        activeD[k] = 1'b0;
                        timerD[k]  = '0;
                    end
                end
            end
        end
    end

    // State register with synchronous active-low reset silencing every voice
    always_ff @(posedge clk) begin
        if (!rstb) begin
            activeQ <= '0;
            noteQ   <= '0;
            timerQ  <= '0;
            startQ  <= '0;
            stealQ  <= 1'b0;
            errCntQ <= '0;
        end else begin
            activeQ <= activeD;
            noteQ   <= noteD;
            timerQ  <= timerD;
            startQ  <= startD;
            stealQ  <= stealD;
            errCntQ <= errCntD;
        end
    end

    assign bus.voiceActive = activeQ;
    assign bus.voiceNote   = noteQ;
    assign bus.voiceStart  = startQ;
    assign bus.steal       = stealQ;
    assign bus.errCnt      = errCntQ;
endmodule

// File: tb/tb_voice_ctrl.sv
// Self-checking bench for voice_ctrl: directed scenarios plus random traffic,
// compared every cycle against a remaining-cycles reference model.
module tb_voice_ctrl;
    localparam int W   = 8;
    localparam int V   = 4;
    localparam int N   = W - 1;
    localparam int EW  = 8;
    localparam int DUR = 10;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic clk  = 1'b0;
    logic rstb = 1'b0;

    voice_ctrl_if #(.C_UART_DATA_WIDTH(W), .C_VOICES(V), .C_ERR_WIDTH(EW)) vif ();

    voice_ctrl #(
        .C_CLK_FRQ(10_000),
        .C_MUSIC(1),
        .C_UART_DATA_WIDTH(W),
        .C_VOICES(V),
        .C_ERR_WIDTH(EW)
    ) dut (
        .clk(clk),
        .rstb(rstb),
        .bus(vif.slave)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: cycles of sound left per voice, last code per voice
    int           left[V];
    logic [N-1:0] mNote[V];
    logic [V-1:0] mStart;
    logic         mSteal;
    int           mErr;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [V-1:0] expActive();
        logic [V-1:0] a;
        for (int k = 0; k < V; k++) a[k] = (left[k] > 0);
        return a;
    endfunction

    function automatic logic [V*N-1:0] expNotes();
        logic [V*N-1:0] n;
        for (int k = 0; k < V; k++) n[k*N +: N] = mNote[k];
        return n;
    endfunction

    task automatic modelEdge(input logic r, input logic v, input logic e, input logic [W-1:0] m);
        int code;
        int pick;
        mStart = '0;
        mSteal = 1'b0;
        if (!r) begin
            for (int k = 0; k < V; k++) begin
                left[k]  = 0;
                mNote[k] = '0;
            end
            mErr = 0;
        end else begin
            for (int k = 0; k < V; k++) if (left[k] > 0) left[k]--;
            if (e) begin
                if (mErr < ERR_MAX) mErr++;
            end else if (v) begin
                code = int'(m[N-1:0]);
                if (m[W-1]) begin
                    if (code != 0) begin
                        pick = -1;
                        for (int k = 0; k < V; k++)
                            if (left[k] > 0 && int'(mNote[k]) == code) pick = k;
                        if (pick < 0)
                            for (int k = 0; k < V; k++)
                                if (pick < 0 && left[k] == 0) pick = k;
                        if (pick < 0) begin
                            pick = 0;
                            for (int k = 1; k < V; k++)
                                if (left[k] < left[pick]) pick = k;
                            mSteal = 1'b1;
                        end
                        left[pick]   = DUR;
                        mNote[pick]  = N'(code);
                        mStart[pick] = 1'b1;
                    end
                end else if (code == 0) begin
                    for (int k = 0; k < V; k++) left[k] = 0;
                end else begin
                    for (int k = 0; k < V; k++)
                        if (left[k] > 0 && int'(mNote[k]) == code) left[k] = 0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic e, input logic [W-1:0] m);
        rstb           = r;
        vif.UART_valid = v;
        vif.UART_err   = e;
        vif.UART_msg   = m;
        @(posedge clk);
        modelEdge(r, v, e, m);
        #1;
        checkOutput("voiceActive", 64'(vif.voiceActive), 64'(expActive()));
        checkOutput("voiceNote",   64'(vif.voiceNote),   64'(expNotes()));
        checkOutput("voiceStart",  64'(vif.voiceStart),  64'(mStart));
        checkOutput("steal",       64'(vif.steal),       64'(mSteal));
        checkOutput("errCnt",      64'(vif.errCnt),      64'(mErr));
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic noteMsg(input logic [W-1:0] m);
        applyStimulus(1'b1, 1'b1, 1'b0, m);
    endtask

    int activeCnt;
    int startCnt;
    logic [W-1:0] rndMsg;

    initial begin
        vif.UART_valid = 1'b0;
        vif.UART_err   = 1'b0;
        vif.UART_msg   = '0;
        for (int k = 0; k < V; k++) begin
            left[k]  = 0;
            mNote[k] = '0;
        end
        mErr   = 0;
        mStart = '0;
        mSteal = 1'b0;

        // Reset then idle
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("resetActive", 64'(vif.voiceActive), 64'h0);
        idleCycles(3);

        // Single note and its duration
        noteMsg(8'h85);
        checkOutput("firstStart", 64'(vif.voiceStart), 64'h1);
        checkOutput("firstNote", 64'(vif.voiceNote[N-1:0]), 64'h05);
        activeCnt = int'(vif.voiceActive[0]);
        for (int i = 0; i < 14; i++) begin
            idleCycles(1);
            activeCnt += int'(vif.voiceActive[0]);
        end
        checkOutput("durVoice0", 64'(activeCnt), 64'(DUR));

        // Fill all voices and steal the oldest
        noteMsg(8'h81);
        noteMsg(8'h82);
        noteMsg(8'h83);
        noteMsg(8'h84);
        noteMsg(8'h86);
        checkOutput("stealPulse", 64'(vif.steal), 64'h1);
        checkOutput("allBusy", 64'(vif.voiceActive), 64'hF);
        checkOutput("stolenNote", 64'(vif.voiceNote[N-1:0]), 64'h06);
        noteMsg(8'h00);
        idleCycles(2);

        // Retrigger the same code
        activeCnt = 0;
        startCnt  = 0;
        noteMsg(8'h81);
        activeCnt += int'(vif.voiceActive[0]);
        startCnt  += int'(vif.voiceStart[0]);
        for (int i = 1; i < 21; i++) begin
            if (i == 5) noteMsg(8'h81);
            else idleCycles(1);
            activeCnt += int'(vif.voiceActive[0]);
            startCnt  += int'(vif.voiceStart[0]);
        end
        checkOutput("retrigActive", 64'(activeCnt), 64'd15);
        checkOutput("retrigStarts", 64'(startCnt), 64'd2);

        // Release paths
        noteMsg(8'h81);
        noteMsg(8'h82);
        noteMsg(8'h02);
        checkOutput("releaseOne", 64'(vif.voiceActive), 64'h1);
        noteMsg(8'h07);
        checkOutput("releaseNoMatch", 64'(vif.voiceActive), 64'h1);
        noteMsg(8'h00);
        checkOutput("releaseAll", 64'(vif.voiceActive), 64'h0);

        // Error counting and saturation
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h55);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h85);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
        checkOutput("errCnt3", 64'(vif.errCnt), 64'd3);
        checkOutput("errNoVoice", 64'(vif.voiceActive), 64'h0);
        repeat (300) applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
        checkOutput("errSat", 64'(vif.errCnt), 64'(ERR_MAX));

        // Expiry coinciding with a note-on for the same code
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        noteMsg(8'h81);
        idleCycles(DUR - 1);
        noteMsg(8'h81);
        checkOutput("expiryNoSteal", 64'(vif.steal), 64'h0);
        checkOutput("expiryStart", 64'(vif.voiceStart), 64'h1);
        activeCnt = int'(vif.voiceActive[0]);
        for (int i = 0; i < 14; i++) begin
            idleCycles(1);
            activeCnt += int'(vif.voiceActive[0]);
        end
        checkOutput("expiryWindow", 64'(activeCnt), 64'(DUR));

        // Reset mid-note
        noteMsg(8'h83);
        idleCycles(3);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("midResetActive", 64'(vif.voiceActive), 64'h0);
        checkOutput("midResetNote", 64'(vif.voiceNote), 64'h0);

        // Random traffic over a small code range to provoke hits and steals
        for (int i = 0; i < 3000; i++) begin
            rndMsg[N-1:0] = ($urandom_range(0, 11) == 0) ? N'(0) : N'($urandom_range(1, 6));
            rndMsg[W-1]   = ($urandom_range(0, 2) != 0);
            applyStimulus(($urandom_range(0, 299) != 0),
                          ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 15) == 0),
                          rndMsg);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
